// File: rtl/uart_pkg.sv
// Shared UART framing definitions used by both the transmitter and receiver.
package uart_pkg;

    localparam logic STARTBIT  = 1'b0;
    localparam logic STOPBIT   = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/simple_uart_rx.sv
// Receive-only 8N1 UART: oversampled start/data/stop recovery feeding a FIFO write port.
//
// state | meaning
// IDLE  | line idle, waiting for a 1->0 transition on the synchronized line
// START | counting to mid start bit, rejecting glitches that are high again
// DATA  | sampling eight data bits, one per bit period, LSB first
// STOP  | sampling the stop bit, issuing wrreq / overrun / framing_err
// BREAK | stop bit was low; waiting for the line to return high
module simple_uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       RX_CLK,
    input  logic       rst,
    input  logic       RX,
    input  logic       wrfull,
    output logic [7:0] data_out,
    output logic       wrreq,
    output logic       framing_err,
    output logic       overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
        $error("simple_uart_rx: OVERSAMPLE must be even and at least 4");
    end

    uart_rx_state_t r_state;
    uart_rx_state_t w_state_nxt;

    logic                  w_rx_s;
    logic                  r_rx_prev;
    logic [TICK_W-1:0]     r_tick;
    logic [BIT_W-1:0]      r_bitn;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_data_out;
    logic                  r_wrreq;
    logic                  r_framing_err;
    logic                  r_overrun;

    logic w_fall;
    logic w_start_smp;
    logic w_bit_smp;
    logic w_stop_smp;
    logic w_tick_clr;
    logic w_wrreq_nxt;
    logic w_overrun_nxt;
    logic w_framing_nxt;

    // Line idles high, so the synchronizer must come out of reset at 1 to avoid a fake start.
    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk (RX_CLK),
        .i_rst (rst),
        .i_d   (RX),
        .o_q   (w_rx_s)
    );

    assign w_fall = r_rx_prev & ~w_rx_s;

    always_ff @(posedge RX_CLK or posedge rst) begin : p_state
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_start_smp) begin
                    w_state_nxt = (w_rx_s == STARTBIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (w_bit_smp && (r_bitn == LAST_BIT)) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_stop_smp) begin
                    w_state_nxt = (w_rx_s == STOPBIT) ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin : p_out
        w_start_smp = 1'b0;
        w_bit_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        w_tick_clr  = 1'b1;
        case (r_state)
            START: begin
                w_start_smp = (r_tick == HALF_TICK);
                w_tick_clr  = w_start_smp;
            end
            DATA: begin
                w_bit_smp  = (r_tick == LAST_TICK);
                w_tick_clr = w_bit_smp;
            end
            STOP: begin
                w_stop_smp = (r_tick == LAST_TICK);
                w_tick_clr = w_stop_smp;
            end
            default: begin
                w_tick_clr = 1'b1;
            end
        endcase
        w_wrreq_nxt   = w_stop_smp && (w_rx_s == STOPBIT) && !wrfull;
        w_overrun_nxt = w_stop_smp && (w_rx_s == STOPBIT) && wrfull;
        w_framing_nxt = w_stop_smp && (w_rx_s != STOPBIT);
    end

    always_ff @(posedge RX_CLK or posedge rst) begin : p_datapath
        if (rst) begin
            r_rx_prev <= 1'b1;
            r_tick    <= '0;
            r_bitn    <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_prev <= w_rx_s;
            if (w_tick_clr) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + TICK_W'(1);
            end
            if (w_start_smp) begin
                r_bitn <= '0;
            end else if (w_bit_smp) begin
                r_bitn <= r_bitn + BIT_W'(1);
            end
            if (w_bit_smp) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge RX_CLK or posedge rst) begin : p_outputs
        if (rst) begin
            r_data_out    <= '0;
            r_wrreq       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_wrreq       <= w_wrreq_nxt;
            r_framing_err <= w_framing_nxt;
            r_overrun     <= w_overrun_nxt;
            if (w_wrreq_nxt) begin
                r_data_out <= r_shift;
            end
        end
    end

    assign data_out    = r_data_out;
    assign wrreq       = r_wrreq;
    assign framing_err = r_framing_err;
    assign overrun     = r_overrun;

endmodule
